// File: rtl/mcs6530_bus_master_if.sv
// Command, response and 6502-side bus bundle for the mcs6530 bus master.
// The master modport is the initiator side; the slave modport is its user/responder side.
`timescale 1ns/1ps
interface mcs6530_bus_master_if #(
    parameter int ADDR_W = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic              cmd_poll;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_rs0;
    logic [7:0]        cmd_wdata;
    logic [7:0]        cmd_mask;
    logic [7:0]        cmd_match;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_rdata;
    logic              rsp_noresp;
    logic              rsp_timeout;
    logic [7:0]        rsp_count;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_rs0;
    logic              bus_cs1;
    logic              bus_we_n;
    logic [7:0]        bus_do;
    logic [7:0]        bus_di;
    logic              bus_oe;

    modport master (
        input  cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_rs0,
        input  cmd_wdata, cmd_mask, cmd_match, rsp_ready, bus_di, bus_oe,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_noresp, rsp_timeout,
        output rsp_count, bus_addr, bus_rs0, bus_cs1, bus_we_n, bus_do
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_rs0,
        output cmd_wdata, cmd_mask, cmd_match, rsp_ready, bus_di, bus_oe,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_noresp, rsp_timeout,
        input  rsp_count, bus_addr, bus_rs0, bus_cs1, bus_we_n, bus_do
    );
endinterface

// File: rtl/mcs6530_bus_master.sv
// 6502-side bus initiator: single read/write cycles plus masked read-poll,
// sequenced IDLE -> ADDR -> DATA -> TURN -> RESP with one idle cycle per read.
`timescale 1ns/1ps
module mcs6530_bus_master #(
    parameter int ADDR_W   = 10,
    parameter int POLL_MAX = 255
) (
    input  logic phi2,
    input  logic rst_n,
    mcs6530_bus_master_if.master bm
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, TURN, RESP} state_t;

    localparam logic [7:0] MAX = 8'(POLL_MAX);

    state_t            state, state_n;
    logic              write_q, poll_q, rs0_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q, mask_q, match_q;
    logic [7:0]        rdata_q, count_q;
    logic              noresp_q, timeout_q;
    logic              hit, spent, on;

    assign hit   = ((rdata_q ^ match_q) & mask_q) == 8'h00;
    assign spent = count_q == MAX;
    assign on    = (state == ADDR) || (state == DATA);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bm.cmd_valid) state_n = ADDR;
            ADDR: state_n = DATA;
            DATA: state_n = TURN;
            TURN: state_n = (!poll_q || hit || spent) ? RESP : ADDR;
            RESP: if (bm.rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            poll_q    <= 1'b0;
            rs0_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            mask_q    <= 8'h00;
            match_q   <= 8'h00;
            rdata_q   <= 8'h00;
            count_q   <= 8'h00;
            noresp_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_n;
            // acceptance also clears the previous response
            if (state == IDLE && bm.cmd_valid) begin
                write_q   <= bm.cmd_write;
                poll_q    <= bm.cmd_poll & ~bm.cmd_write;
                rs0_q     <= bm.cmd_rs0;
                addr_q    <= bm.cmd_addr;
                wdata_q   <= bm.cmd_wdata;
                mask_q    <= bm.cmd_mask;
                match_q   <= bm.cmd_match;
                rdata_q   <= 8'h00;
                count_q   <= 8'h00;
                noresp_q  <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (state == DATA && !write_q) begin
                rdata_q  <= bm.bus_di;
                noresp_q <= noresp_q | ~bm.bus_oe;
                if (count_q != 8'hFF) count_q <= count_q + 8'd1;
            end
            if (state == TURN && poll_q && !hit && spent) timeout_q <= 1'b1;
        end
    end

    assign bm.cmd_ready   = state == IDLE;
    assign bm.rsp_valid   = state == RESP;
    assign bm.rsp_rdata   = rdata_q;
    assign bm.rsp_noresp  = noresp_q;
    assign bm.rsp_timeout = timeout_q;
    assign bm.rsp_count   = count_q;
    assign bm.bus_addr    = on ? addr_q : '0;
    assign bm.bus_rs0     = on & rs0_q;
    assign bm.bus_cs1     = on;
    assign bm.bus_we_n    = ~(on & write_q);
    assign bm.bus_do      = (on & write_q) ? wdata_q : 8'h00;
endmodule

// File: doc/mcs6530_bus_master.md
Name: mcs6530_bus_master

Overview:
- Synchronous 6502-side bus initiator that drives the mcs6530 responder: addr, chip select, RS0, R/W, write data; samples read data and OE.
- Converts valid/ready command requests into single read/write bus cycles, plus a read-poll mode that repeats a read until a masked match or a timeout.
- Sits in the simulation and FPGA test harness as the CPU stand-in feeding the mcs6530 instance.

Parameters:
- ADDR_W, 10, width of bus address.
- POLL_MAX, 255, maximum reads per poll command (1..255); reads are counted in 8 bits.

Ports:
- phi2  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command.
- cmd_write  input  1  1=write, 0=read.
- cmd_poll  input  1  read-poll mode; ignored when cmd_write=1.
- cmd_addr  input  ADDR_W  target address.
- cmd_rs0  input  1  RAM/ROM select driven on RS0.
- cmd_wdata  input  8  write data.
- cmd_mask  input  8  poll mask.
- cmd_match  input  8  poll compare value.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  8  last sampled read data (0x00 for writes).
- rsp_noresp  output  1  a read sampled bus_oe=0.
- rsp_timeout  output  1  poll exhausted POLL_MAX reads without a match.
- rsp_count  output  8  number of bus reads performed (0 for writes).
- bus_addr  output  ADDR_W  address to responder A.
- bus_rs0  output  1  to responder RS0.
- bus_cs1  output  1  to responder CS1, active high.
- bus_we_n  output  1  to responder we_n; 1=read.
- bus_do  output  8  write data to responder DI.
- bus_di  input  8  read data from responder DO.
- bus_oe  input  1  responder drives data.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, cmd_ready=1, rsp_valid=0, rsp_* fields=0, bus_addr=0, bus_rs0=0, bus_cs1=0, bus_we_n=1, bus_do=0, poll counter=0. Reset mid-transaction abandons it; no response is produced.
- States: IDLE, ADDR, DATA, TURN, RESP.
- IDLE: cmd_ready=1; bus at idle values. When cmd_valid=1, latch all cmd_* fields and go to ADDR.
- ADDR: cmd_ready=0. Drive bus_cs1=1, bus_addr, bus_rs0, bus_we_n=~write, and bus_do=wdata for writes (0 for reads). Go to DATA.
- DATA: hold all bus signals unchanged. At the exiting edge:
  - For a read, capture bus_di into rsp_rdata, set noresp to the OR of ~bus_oe, and increment the count (saturating at 255).
  - Go to TURN.
- TURN: bus returns to idle values for exactly one cycle. Then:
  - Write or plain read: go to RESP.
  - Poll, when (rdata & mask) == (match & mask): go to RESP with timeout=0.
  - Poll, no match and count == POLL_MAX: go to RESP with timeout=1.
  - Poll otherwise: go to ADDR and re-issue the same read.
- RESP: rsp_valid=1, all rsp_* fields stable. Leave for IDLE on an edge where rsp_ready=1.
  - rsp_ready may already be high when RESP is entered; rsp_valid is then high for exactly one cycle.
  - Response fields are cleared on entry to ADDR of the next command.
- Latency: the command is accepted at edge E0. Then ADDR spans E0–E1, DATA spans E1–E2, TURN spans E2–E3, and rsp_valid is high from E3. The minimum issue-to-issue period is 5 cycles.
- Poll with N reads: rsp_valid rises 3N cycles after acceptance. Bus idle cycles occur between reads (TURN).
- rsp_noresp is sticky across all reads of one poll. Data is still captured when bus_oe=0.
- A write never samples bus_di; rsp_rdata=0, rsp_count=0, rsp_noresp=0, rsp_timeout=0.
- cmd_valid while cmd_ready=0 is ignored; no queueing.
- Any cmd_mask=0 poll matches on the first read (count=1).

Test Plan:
- Write addr 0x3F0, rs0=0, wdata 0xA5 -> cs1=1/we_n=0/bus_do=0xA5 for exactly 2 cycles, rsp_valid at E3, rsp_rdata=0x00, rsp_count=0.
- Read addr 0x3F0 after that write, responder returns 0xA5 with oe=1 -> rsp_rdata=0xA5, rsp_noresp=0, rsp_count=1, we_n=1 throughout.
- Read with bus_oe held 0, bus_di=0x5A -> rsp_rdata=0x5A, rsp_noresp=1.
- Poll with mask 0x80, match 0x80, bit 7 set on the 4th read -> exactly 4 cs1 pulses with an idle cycle between each, rsp_count=4, rsp_timeout=0, rsp_valid 12 cycles after accept.
- Poll that never matches, POLL_MAX=255 -> 255 reads, rsp_timeout=1, rsp_count=255. Repeat with POLL_MAX=3 -> count=3.
- rst_n low during DATA of a write -> next edge gives cs1=0, we_n=1, cmd_ready=1, no rsp_valid. A new read issued immediately completes normally. Also: rsp_ready held low for 5 cycles keeps rsp_valid and fields stable and cmd_ready=0.
